// File: rtl/water_level_pkg.sv
// Shared types and decode helpers for the tank level monitor.
// Thermometer decode of the {high, mid, low} sensor vector plus the FSM next-state rule.
package water_level_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam logic [1:0] LEVEL_EMPTY = 2'd0;
  localparam logic [1:0] LEVEL_FULL  = 2'd3;

  typedef struct packed {
    logic [1:0] level;
    logic       valid;
  } level_dec_t;

  function automatic level_dec_t thermo_decode(input logic [2:0] v);
    level_dec_t d;
    d.valid = 1'b1;
    d.level = LEVEL_EMPTY;
    case (v)
      3'b000:  d.level = LEVEL_EMPTY;
      3'b001:  d.level = 2'd1;
      3'b011:  d.level = 2'd2;
      3'b111:  d.level = LEVEL_FULL;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  // Mid levels keep FILLING/READY as they are; that is the hysteresis band.
  function automatic state_t next_state(input state_t cur, input level_dec_t d);
    state_t n;
    n = cur;
    if (!d.valid) begin
      n = FAULT;
    end else begin
      case (cur)
        INIT, FAULT: n = (d.level == LEVEL_FULL) ? READY : FILLING;
        FILLING:     if (d.level == LEVEL_FULL) n = READY;
        READY:       if (d.level == LEVEL_EMPTY) n = FILLING;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// 2-FF synchronizer plus stability counter; a vector is accepted after DEBOUNCE_CYCLES identical samples.
// Accept strobe and accepted vector register DEBOUNCE_CYCLES+1 edges after the raw sample; no backpressure.
module sensor_debouncer #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset_pulse,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_accepted,
  output logic             o_accept_stb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [1:0]       r_sync_vld;
  logic [WIDTH-1:0] r_cand;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic             r_have_acc;
  logic             r_stb;

  logic w_same;
  logic w_fire;

  assign w_same = (r_sync2 == r_cand);
  // The first stable vector after reset is always accepted, even if it matches the reset value.
  assign w_fire = r_sync_vld[1] && w_same && (r_cnt == CNT_LAST) &&
                  (!r_have_acc || (r_cand != r_acc));

  always_ff @(posedge clock) begin
    if (reset_pulse) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_sync_vld <= '0;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_have_acc <= 1'b0;
      r_stb      <= 1'b0;
    end else begin
      r_sync1    <= i_raw;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_stb      <= w_fire;
      if (w_fire) begin
        r_acc      <= r_cand;
        r_have_acc <= 1'b1;
      end
      // Synchronizer contents left over from reset are not real samples.
      if (!r_sync_vld[1]) begin
        r_cnt <= '0;
      end else if ((r_cnt == '0) || !w_same) begin
        r_cand <= r_sync2;
        r_cnt  <= CW'(1);
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_accepted   = r_acc;
  assign o_accept_stb = r_stb;

endmodule

// File: rtl/water_level_monitor.sv
// Debounced tank level decode driving watering/filling requests with hysteresis and fault blocking.
// Outputs register DEBOUNCE_CYCLES+2 edges after a held raw sample; no backpressure.
module water_level_monitor #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_pulse,
  input  logic [2:0] water_sensors,
  output logic [1:0] level,
  output logic       watering_condition,
  output logic       filling_condition,
  output logic       sensor_fault,
  output logic       level_changed
);

  import water_level_pkg::*;

  logic [2:0] w_accepted;
  logic       w_accept_stb;
  level_dec_t w_dec;
  state_t     w_next;

  state_t     r_state;
  logic [1:0] r_level;
  logic       r_water;
  logic       r_fill;
  logic       r_fault;
  logic       r_level_changed;

  sensor_debouncer #(
    .WIDTH          (3),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock       (clock),
    .reset_pulse (reset_pulse),
    .i_raw       (water_sensors),
    .o_accepted  (w_accepted),
    .o_accept_stb(w_accept_stb)
  );

  assign w_dec  = thermo_decode(w_accepted);
  assign w_next = next_state(r_state, w_dec);

  always_ff @(posedge clock) begin
    if (reset_pulse) begin
      r_state         <= INIT;
      r_level         <= LEVEL_EMPTY;
      r_water         <= 1'b0;
      r_fill          <= 1'b0;
      r_fault         <= 1'b0;
      r_level_changed <= 1'b0;
    end else begin
      r_level_changed <= 1'b0;
      if (w_accept_stb) begin
        r_state <= w_next;
        r_fill  <= (w_next == FILLING);
        r_water <= (w_next == READY);
        r_fault <= (w_next == FAULT);
        // Level holds through a fault so the last trustworthy reading stays visible.
        if (w_dec.valid && (w_dec.level != r_level)) begin
          r_level         <= w_dec.level;
          r_level_changed <= 1'b1;
        end
      end
    end
  end

  assign level              = r_level;
  assign watering_condition = r_water;
  assign filling_condition  = r_fill;
  assign sensor_fault       = r_fault;
  assign level_changed      = r_level_changed;

endmodule

// File: tb/tb_water_level_monitor.sv
// Bench for water_level_monitor: directed vector table plus random holds against a history-based model.
module tb_water_level_monitor;

  localparam int DC = 4;

  logic       clock = 1'b0;
  logic       reset_pulse;
  logic [2:0] water_sensors;
  logic [1:0] level;
  logic       watering_condition;
  logic       filling_condition;
  logic       sensor_fault;
  logic       level_changed;

  always #5 clock = ~clock;

  water_level_monitor #(.DEBOUNCE_CYCLES(DC)) dut (
    .clock             (clock),
    .reset_pulse       (reset_pulse),
    .water_sensors     (water_sensors),
    .level             (level),
    .watering_condition(watering_condition),
    .filling_condition (filling_condition),
    .sensor_fault      (sensor_fault),
    .level_changed     (level_changed)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: raw sample history since reset, plus the visible outputs.
  int         hist[$];
  bit         m_have;
  int         m_acc;
  bit         m_pend;
  int         m_pend_v;
  logic [1:0] m_level;
  logic       m_fill, m_water, m_fault, m_chg;

  function automatic bit is_thermo(input int v);
    return (v == 0) || (v == 1) || (v == 3) || (v == 7);
  endfunction

  task automatic apply_accept(input int v);
    logic [1:0] lv;
    if (!is_thermo(v)) begin
      m_fault = 1'b1;
      m_fill  = 1'b0;
      m_water = 1'b0;
    end else begin
      lv      = 2'($countones(3'(v)));
      m_fault = 1'b0;
      if (lv != m_level) begin
        m_level = lv;
        m_chg   = 1'b1;
      end
      if (lv == 2'd3) begin
        m_water = 1'b1;
        m_fill  = 1'b0;
      end else if (lv == 2'd0) begin
        m_fill  = 1'b1;
        m_water = 1'b0;
      end else if (!m_fill && !m_water) begin
        m_fill = 1'b1;
      end
    end
  endtask

  task automatic model_edge(input logic rst, input logic [2:0] s);
    int  n;
    int  x;
    bit  stable;
    bit  fresh;
    if (rst) begin
      hist.delete();
      m_have  = 1'b0;
      m_acc   = 0;
      m_pend  = 1'b0;
      m_level = 2'd0;
      m_fill  = 1'b0;
      m_water = 1'b0;
      m_fault = 1'b0;
      m_chg   = 1'b0;
    end else begin
      m_chg = 1'b0;
      if (m_pend) apply_accept(m_pend_v);
      m_pend = 1'b0;
      // Accept when the samples up to two edges ago form a run of exactly DC identical values.
      n = hist.size();
      if (n >= DC + 1) begin
        x      = hist[n-2];
        stable = 1'b1;
        for (int k = n - 1 - DC; k <= n - 2; k++)
          if (hist[k] != x) stable = 1'b0;
        fresh = (n - 2 - DC < 0) ? 1'b1 : (hist[n-2-DC] != x);
        if (stable && fresh && (!m_have || (x != m_acc))) begin
          m_pend   = 1'b1;
          m_pend_v = x;
          m_acc    = x;
          m_have   = 1'b1;
        end
      end
      hist.push_back(int'(s));
    end
  endtask

  task automatic cycle(input logic rst, input logic [2:0] s);
    logic [5:0] got;
    logic [5:0] exp;
    reset_pulse   = rst;
    water_sensors = s;
    @(posedge clock);
    model_edge(rst, s);
    #1;
    cyc++;
    checks++;
    got = {level, filling_condition, watering_condition, sensor_fault, level_changed};
    exp = {m_level, m_fill, m_water, m_fault, m_chg};
    if (got !== exp) begin
      failures++;
      $display("FAIL model_cycle%0d got={lvl,fill,water,fault,chg}=%b expected=%b", cyc, got, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] sens;
    int         ncyc;
    logic [1:0] lvl;
    logic       fill;
    logic       water;
    logic       fault;
    int         pulses;
  } vec_t;

  vec_t rows[$];

  function automatic vec_t mk(input logic rst, input logic [2:0] sens, input int ncyc,
                              input logic [1:0] lvl, input logic fill, input logic water,
                              input logic fault, input int pulses);
    vec_t v;
    v.rst = rst; v.sens = sens; v.ncyc = ncyc; v.lvl = lvl;
    v.fill = fill; v.water = water; v.fault = fault; v.pulses = pulses;
    return v;
  endfunction

  initial begin
    int         pulses;
    logic [4:0] got;
    logic [4:0] exp;
    logic [2:0] vals;
    int         valid_set[4];

    rows.push_back(mk(1'b1, 3'b000,  1, 2'd0, 1'b0, 1'b0, 1'b0, 0)); // reset
    rows.push_back(mk(1'b0, 3'b000,  6, 2'd0, 1'b0, 1'b0, 1'b0, 0)); // edges t..t+5 quiet
    rows.push_back(mk(1'b0, 3'b000,  4, 2'd0, 1'b1, 1'b0, 1'b0, 0)); // first accept -> FILLING
    rows.push_back(mk(1'b0, 3'b001, 10, 2'd1, 1'b1, 1'b0, 1'b0, 1));
    rows.push_back(mk(1'b0, 3'b011, 10, 2'd2, 1'b1, 1'b0, 1'b0, 1));
    rows.push_back(mk(1'b0, 3'b111, 10, 2'd3, 1'b0, 1'b1, 1'b0, 1));
    rows.push_back(mk(1'b0, 3'b011, 10, 2'd2, 1'b0, 1'b1, 1'b0, 1)); // hysteresis
    rows.push_back(mk(1'b0, 3'b001, 10, 2'd1, 1'b0, 1'b1, 1'b0, 1));
    rows.push_back(mk(1'b0, 3'b000, 10, 2'd0, 1'b1, 1'b0, 1'b0, 1));
    rows.push_back(mk(1'b0, 3'b111, 10, 2'd3, 1'b0, 1'b1, 1'b0, 1));
    rows.push_back(mk(1'b0, 3'b011,  3, 2'd3, 1'b0, 1'b1, 1'b0, 0)); // short glitch
    rows.push_back(mk(1'b0, 3'b111, 10, 2'd3, 1'b0, 1'b1, 1'b0, 0));
    rows.push_back(mk(1'b0, 3'b101, 10, 2'd3, 1'b0, 1'b0, 1'b1, 0)); // fault, level held
    rows.push_back(mk(1'b0, 3'b011, 10, 2'd2, 1'b1, 1'b0, 1'b0, 1)); // recover to FILLING
    rows.push_back(mk(1'b0, 3'b111, 10, 2'd3, 1'b0, 1'b1, 1'b0, 1));
    rows.push_back(mk(1'b0, 3'b011,  3, 2'd3, 1'b0, 1'b1, 1'b0, 0)); // mid-debounce
    rows.push_back(mk(1'b1, 3'b011,  1, 2'd0, 1'b0, 1'b0, 1'b0, 0)); // reset wins
    rows.push_back(mk(1'b0, 3'b011,  6, 2'd0, 1'b0, 1'b0, 1'b0, 0));
    rows.push_back(mk(1'b0, 3'b011,  1, 2'd2, 1'b1, 1'b0, 1'b0, 1));

    foreach (rows[r]) begin
      pulses = 0;
      for (int c = 0; c < rows[r].ncyc; c++) begin
        cycle(rows[r].rst, rows[r].sens);
        if (level_changed) pulses++;
      end
      checks++;
      got = {level, filling_condition, watering_condition, sensor_fault};
      exp = {rows[r].lvl, rows[r].fill, rows[r].water, rows[r].fault};
      if ((got !== exp) || (pulses != rows[r].pulses)) begin
        failures++;
        $display("FAIL row%0d got={lvl,fill,water,fault}=%b pulses=%0d expected=%b pulses=%0d",
                 r, got, pulses, exp, rows[r].pulses);
      end
    end

    valid_set = '{0, 1, 3, 7};
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 3) == 0) vals = 3'($urandom_range(0, 7));
      else                           vals = 3'(valid_set[$urandom_range(0, 3)]);
      if ($urandom_range(0, 39) == 0) begin
        cycle(1'b1, vals);
      end else begin
        for (int c = $urandom_range(1, 8); c > 0; c--) cycle(1'b0, vals);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
